// File: rtl/bcd2bin_seq_pkg.sv
// bcd2bin_seq_pkg: shared types and constants for the sequential BCD-to-binary converter
package bcd2bin_seq_pkg;
  localparam int BIN_W = 7;
  localparam int N_ITER = 7;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB = 4'd3;
  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction, subtract 3 from digits >= 8
module bcd_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= ADJ_THRESH) ? d - ADJ_SUB : d;
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: two-digit BCD to 7-bit binary via 7 shift-and-correct iterations
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  output logic             ready,
  output logic             done_tick,
  output logic [BIN_W-1:0] bin
);
  state_t state_q, state_d;
  logic [3:0] bcd1_q, bcd1_d, bcd0_q, bcd0_d, adj1, adj0;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [2:0] n_q, n_d;
  logic [8+BIN_W-1:0] sh;
  assign sh = {bcd1_q, bcd0_q, bin_q} >> 1;
  bcd_digit_adj u_adj1 (.d(sh[14:11]), .q(adj1));
  bcd_digit_adj u_adj0 (.d(sh[10:7]), .q(adj0));
  // next state: capture on start, shift and correct in OP, single DONE cycle
  always_comb begin
    state_d = state_q;
    bcd1_d = bcd1_q;
    bcd0_d = bcd0_q;
    bin_d = bin_q;
    n_d = n_q;
    unique case (state_q)
      IDLE: if (start) begin
        bcd1_d = bcd1;
        bcd0_d = bcd0;
        bin_d = '0;
        n_d = 3'(N_ITER - 1);
        state_d = OP;
      end
      OP: begin
        bcd1_d = adj1;
        bcd0_d = adj0;
        bin_d = sh[BIN_W-1:0];
        n_d = (n_q == 3'd0) ? n_q : n_q - 3'd1;
        state_d = (n_q == 3'd0) ? DONE : OP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcd1_q <= '0;
      bcd0_q <= '0;
      bin_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      bcd1_q <= bcd1_d;
      bcd0_q <= bcd0_d;
      bin_q <= bin_d;
      n_q <= n_d;
    end
  end
  assign ready = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign bin = bin_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: scoreboard bench for bcd2bin_seq with a cycle-level timing reference
module tb_bcd2bin_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ready, done_tick;
  logic [3:0] bcd1 = '0, bcd0 = '0;
  logic [6:0] bin;
  int n_chk = 0, n_pass = 0;
  int ref_cnt = 0, hold = 0, cur = 0;
  int exp_q[$];

  bcd2bin_seq dut (.clk(clk), .reset(reset), .start(start), .bcd1(bcd1), .bcd0(bcd0),
                   .ready(ready), .done_tick(done_tick), .bin(bin));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // timing reference: 0 idle, 8..2 OP, 1 DONE; results queued on accepted start
  always @(posedge clk) begin
    if (reset) begin
      ref_cnt <= 0;
      hold <= 0;
      cur <= 0;
      exp_q.delete();
    end else if (ref_cnt == 0 && start) begin
      exp_q.push_back(10 * int'(bcd1) + int'(bcd0));
      cur <= 10 * int'(bcd1) + int'(bcd0);
      ref_cnt <= 8;
    end else if (ref_cnt > 0) begin
      if (ref_cnt == 1) hold <= cur;
      ref_cnt <= ref_cnt - 1;
    end
  end

  // monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    chk("ready", int'(ready), int'(ref_cnt == 0));
    chk("done_tick", int'(done_tick), int'(ref_cnt == 1));
    if (ref_cnt == 1) begin
      chk("q_size", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("bin", int'(bin), exp_q.pop_front());
    end
    if (ref_cnt == 0) chk("bin_hold", int'(bin), hold);
  end

  task automatic conv(input int a, input int b);
    int k;
    @(negedge clk);
    bcd1 = 4'(a);
    bcd0 = 4'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 8);
    chk("conv_bin", int'(bin), 10 * a + b);
  endtask

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done_tick), 0);
    chk("rst_bin", int'(bin), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_bin", int'(bin), 0);
    conv(9, 9);
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        conv(a, b);
    @(negedge clk);
    bcd1 = 4'd3;
    bcd0 = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bcd1 = 4'd8;
    bcd0 = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !done_tick; k++) @(negedge clk);
    chk("ignored_start_bin", int'(bin), 37);
    repeat (4) @(negedge clk);
    chk("held_bin", int'(bin), 37);
    start = 1'b1;
    dones = 0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      bcd1 = 4'($urandom_range(9));
      bcd0 = 4'($urandom_range(9));
      if (done_tick) dones++;
    end
    start = 1'b0;
    chk("b2b_dones", dones, 3);
    repeat (2) @(negedge clk);
    bcd1 = 4'd6;
    bcd0 = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_bin", int'(bin), 0);
    repeat (8) @(negedge clk);
    chk("abort_no_done", int'(bin), 0);
    conv(5, 2);
    repeat (2) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
